// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone burst master: cycle-type codes and the
// FSM state encoding.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } wbm_state_t;

endpackage

// File: rtl/wb_burst_master_if.sv
// Command, write-stream, read-return and Wishbone signals of the burst master,
// bundled so the agent and the memory side can be wired as one port.
interface wb_burst_master_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int LEN_W = 9
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits for ready, and payload is stable while valid.
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [AW-1:0]     cmd_addr_i;
    logic [LEN_W-1:0]  cmd_len_i;
    logic              cmd_we_i;
    logic [DW/8-1:0]   cmd_sel_i;

    logic [DW-1:0]     wdata_i;
    logic              wdata_valid_i;
    logic              wdata_ready_o;

    logic [DW-1:0]     rdata_o;
    logic              rdata_valid_o;
    logic              done_o;
    logic              err_o;
    logic              busy_o;

    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [AW-1:0]     wb_addr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [DW/8-1:0]   wb_sel_o;
    logic [2:0]        wb_cti_o;
    logic [DW-1:0]     wb_dat_i;
    logic              wb_ack_i;

    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_len_i, cmd_we_i, cmd_sel_i,
        input  wdata_i, wdata_valid_i,
        input  wb_dat_i, wb_ack_i,
        output cmd_ready_o, wdata_ready_o,
        output rdata_o, rdata_valid_o, done_o, err_o, busy_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
    );

    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_len_i, cmd_we_i, cmd_sel_i,
        output wdata_i, wdata_valid_i,
        output wb_dat_i, wb_ack_i,
        input  cmd_ready_o, wdata_ready_o,
        input  rdata_o, rdata_valid_o, done_o, err_o, busy_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
    );

endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 initiator: turns one command into a classic or incrementing
// burst, with a one-word write holding register and an ack watchdog.
module wb_burst_master
    import wb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LEN_W   = 9,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wb_burst_master_if.master  bus,
    output wbm_state_t         dbg_state_o
);

    wbm_state_t        state;
    logic [AW-1:0]     addr;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  fetch_left;
    logic [DW/8-1:0]   sel;
    logic              hold_v;
    logic [DW-1:0]     hold_data;
    logic [TO_W-1:0]   to_cnt;
    logic              ready_q;
    logic              done_q;
    logic              err_q;
    logic              rvalid_q;
    logic [DW-1:0]     rdata_q;

    logic              cyc;
    logic              stb;
    logic              beat;
    logic              last_beat;
    logic              wd_ready;
    logic              take;
    logic              accept;
    logic              to_hit;
    logic [LEN_W-1:0]  len_eff;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^bus.cmd_addr_i[1:0];

    assign cyc       = (state != IDLE);
    assign stb       = (state == READ) || ((state == WRITE) && hold_v);
    assign beat      = stb && bus.wb_ack_i;
    assign last_beat = beat && (remaining == LEN_W'(1));
    // The holding register may refill in the same cycle its word is acked,
    // which keeps writes at one beat per cycle.
    assign wd_ready  = (state == WRITE) && (fetch_left != '0) && (!hold_v || beat);
    assign take      = wd_ready && bus.wdata_valid_i;
    assign accept    = ready_q && bus.cmd_valid_i;
    assign to_hit    = stb && !bus.wb_ack_i && (to_cnt == TO_W'(TIMEOUT - 1));
    assign len_eff   = (bus.cmd_len_i == '0) ? LEN_W'(1) : bus.cmd_len_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            fetch_left <= '0;
            sel        <= '0;
            hold_v     <= 1'b0;
            hold_data  <= '0;
            to_cnt     <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    hold_v  <= 1'b0;
                    to_cnt  <= '0;
                    if (accept) begin
                        ready_q    <= 1'b0;
                        addr       <= {bus.cmd_addr_i[AW-1:2], 2'b00};
                        remaining  <= len_eff;
                        fetch_left <= len_eff;
                        sel        <= bus.cmd_sel_i;
                        err_q      <= 1'b0;
                        state      <= bus.cmd_we_i ? WRITE : READ;
                    end
                end
                WRITE, READ: begin
                    if (take) begin
                        hold_data  <= bus.wdata_i;
                        hold_v     <= 1'b1;
                        fetch_left <= fetch_left - LEN_W'(1);
                    end else if (beat) begin
                        hold_v <= 1'b0;
                    end
                    if ((state == READ) && beat) begin
                        rdata_q  <= bus.wb_dat_i;
                        rvalid_q <= 1'b1;
                    end
                    // Only strobed, unacked cycles feed the watchdog; write
                    // wait states with stb low are the upstream's problem.
                    if (beat) begin
                        addr      <= addr + AW'(4);
                        remaining <= remaining - LEN_W'(1);
                        to_cnt    <= '0;
                    end else if (stb) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                    if (last_beat || to_hit) begin
                        state   <= IDLE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        hold_v  <= 1'b0;
                        if (to_hit) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state_o       = state;

    assign bus.cmd_ready_o   = ready_q;
    assign bus.wdata_ready_o = wd_ready;
    assign bus.rdata_o       = rdata_q;
    assign bus.rdata_valid_o = rvalid_q;
    assign bus.done_o        = done_q;
    assign bus.err_o         = err_q;
    assign bus.busy_o        = cyc;

    // Outside a cycle everything but the address is forced to zero.
    assign bus.wb_cyc_o  = cyc;
    assign bus.wb_stb_o  = stb;
    assign bus.wb_we_o   = (state == WRITE);
    assign bus.wb_addr_o = addr;
    assign bus.wb_dat_o  = (state == WRITE) ? hold_data : '0;
    assign bus.wb_sel_o  = cyc ? sel : '0;
    assign bus.wb_cti_o  = !cyc                       ? CTI_CLASSIC :
                           (remaining == LEN_W'(1))   ? CTI_EOB     : CTI_INCR;

endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Wishbone B3 bus master that converts simple command/stream requests into classic or incrementing-burst Wishbone cycles toward the SDRAM memory controller's Wishbone slave port (wb2sdrc side). It is the initiator end of that interface. It provides testbench and on-chip agents with a burst write/read engine, per-beat address generation, CTI signalling and an ack-timeout watchdog.

## Interface

Parameters:
- AW, 32: Wishbone byte-address width.
- DW, 32: data width. Must be 32; the address step is 4 bytes per beat.
- LEN_W, 9: width of the burst-length field (words). Matches the controller's burst-length width.
- TO_W, 8: width of the timeout counter.
- TIMEOUT, 255: wait cycles without ack before abort. Range 1..2^TO_W-1.

Ports:
- wb_clk_i, in, 1: single clock. Everything is on the rising edge.
- wb_rst_i, in, 1: reset. It is synchronous and active-high.
- cmd_valid_i, in, 1: command request.
- cmd_ready_o, out, 1: command accepted when this and cmd_valid_i are both high.
- cmd_addr_i, in, AW: start byte address. Bits [1:0] are ignored (forced 0).
- cmd_len_i, in, LEN_W: number of words. 0 is treated as 1.
- cmd_we_i, in, 1: 1 for write, 0 for read.
- cmd_sel_i, in, DW/8: byte select, applied to every beat.
- wdata_i, in, DW: write-data stream payload.
- wdata_valid_i, in, 1: write-data stream valid.
- wdata_ready_o, out, 1: write-data stream ready.
- rdata_o, out, DW: read data, registered.
- rdata_valid_o, out, 1: one-cycle pulse per read beat. No backpressure.
- done_o, out, 1: one-cycle pulse at the end of a command (normal or aborted).
- err_o, out, 1: sticky timeout flag. Cleared on the next command accept.
- busy_o, out, 1: high whenever the state is not IDLE.
- wb_cyc_o, out, 1: Wishbone cycle.
- wb_stb_o, out, 1: Wishbone strobe.
- wb_we_o, out, 1: Wishbone write enable.
- wb_addr_o, out, AW: Wishbone address.
- wb_dat_o, out, DW: Wishbone write data.
- wb_sel_o, out, DW/8: Wishbone byte select.
- wb_cti_o, out, 3: Wishbone cycle type identifier.
- wb_dat_i, in, DW: Wishbone read data.
- wb_ack_i, in, 1: Wishbone acknowledge.

## Operation

- FSM states: IDLE, WRITE, READ.
- IDLE:
  - cmd_ready_o=1.
  - On accept, latch addr, len (0→1), we and sel; set remaining=len; clear err_o.
  - Go to WRITE or READ.
- Beat tracking:
  - A beat completes when wb_stb_o and wb_ack_i are both high.
  - On each beat: addr += 4 (wraps modulo 2^AW); remaining -= 1.
- WRITE: a one-word holding register, hold_v, feeds wb_dat_o.
  - wdata_ready_o = WRITE && remaining_to_fetch>0 && (!hold_v || beat).
  - wb_stb_o = hold_v.
  - While no data is held, wb_cyc_o stays high and wb_stb_o is low (wait state).
- READ:
  - wb_stb_o=1 for the whole transfer.
  - On each beat: rdata_o<=wb_dat_i and rdata_valid_o=1 on the following cycle.
- wb_cti_o:
  - 3'b111 when the presented beat is the last one (remaining==1).
  - Otherwise 3'b010 (incrementing burst).
  - A length of 1 is therefore a single end-of-burst access.
- End of command: on the last beat, drop cyc/stb at the next edge, pulse done_o, go to IDLE.
- Watchdog:
  - The counter clears on each beat and on entry to WRITE/READ.
  - It increments each cycle wb_stb_o is high without an ack.
  - When it reaches TIMEOUT: drop cyc/stb, set err_o, pulse done_o, go to IDLE.
  - Write words not yet fetched are left in the upstream stream.
  - Wait cycles in WRITE with stb low do not count.
- When the slave is idle (wb_cyc_o=0), all wb_* outputs are 0 except wb_addr_o, which holds its last value.

## Timing

- Reset values: every output is 0 (including cmd_ready_o). cmd_ready_o rises the cycle after reset is released.
- Asserting reset mid-burst drops cyc/stb at that edge. No done_o is produced.
- Command accept at edge N: wb_cyc_o=1 from N+1.
  - READ: wb_stb_o=1 from N+1.
  - WRITE: wb_stb_o=1 one cycle after the first data word is taken.
- Sustained throughput is 1 beat/cycle when the slave acks every cycle and, for writes, wdata_valid_i is held high.
- The last beat is acked at edge M. At M+1: cyc=stb=0, done_o=1 and cmd_ready_o=1. A new command can be accepted at M+1.
- rdata_valid_o for the final beat coincides with done_o.
- A wb_ack_i arriving while wb_stb_o=0 is ignored.

## Structure

- Shared package wb_pkg holds:
  - CTI constants: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - The state enum typedef wbm_state_t.
- The block is a single module with no sub-modules. The holding register is inline.

## Test plan

- Single write: cmd addr=0x100, len=1, we=1, data 0xDEADBEEF; slave acks at the 1st stb cycle. Required: one beat with cti=111, addr=0x100, sel=cmd_sel, then done_o.
- Burst write len=4 at 0x200 with data stalled 2 cycles before word 3. Required: addrs 0x200/204/208/20C; cti 010,010,010,111; stb low during the stall; err_o=0.
- Burst read len=8 at 0x3F0; slave acks every cycle. Required: 8 rdata_valid_o pulses in consecutive cycles; done_o coincides with the 8th pulse; cyc high for exactly 8 cycles.
- Timeout: read len=2; slave never acks. Required: after 255 stb cycles, cyc drops, err_o=1, done_o pulses; the next accept clears err_o.
- Reset mid-burst: assert wb_rst_i during beat 3 of 6. Required: all outputs 0 at that edge; no done_o; a fresh command afterwards runs correctly.
- Address wrap: AW=32, start 0xFFFFFFFC, len=2. Required: 2nd beat address is 0x00000000.
